mfe_lcd1602_text_writer: RTL and testbench

MFE_LCD1602_TEXT_WRITER -- requirements
Module: mfe_lcd1602_text_writer

---
 rtl/mfe_lcd1602_pkg.sv | 25 ++
 rtl/mfe_lcd1602_frame_buf.sv | 31 +++
 rtl/mfe_lcd1602_text_writer.sv | 154 +++++++++++++++
 tb/tb_mfe_lcd1602_text_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfe_lcd1602_pkg.sv
// Shared definitions for the LCD1602 text writer: FSM states, DDRAM line
// base addresses, line geometry and the blank character.
package mfe_lcd1602_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_CHAR = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] LINE0_ADDR = 8'h00;
    localparam logic [7:0] LINE1_ADDR = 8'h40;
    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam int         LINE_LEN   = 16;
    localparam int         BUF_DEPTH  = 2 * LINE_LEN;

    localparam logic [4:0] LINE0_LAST = 5'(LINE_LEN - 1);
    localparam logic [4:0] BUF_LAST   = 5'(BUF_DEPTH - 1);

    function automatic logic [7:0] line_addr(input logic line);
        return line ? LINE1_ADDR : LINE0_ADDR;
    endfunction

endpackage

// File: rtl/mfe_lcd1602_frame_buf.sv
// 32 x 8 character frame buffer: one synchronous write port, one
// combinational read port, reset to all spaces.
module mfe_lcd1602_frame_buf
    import mfe_lcd1602_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [BUF_DEPTH];

    // NOTE: the whole array has an async reset, so this maps to flops rather
    // than a RAM macro; a cleared screen after reset depends on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= SPACE_CHAR;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mfe_lcd1602_text_writer.sv
// Streams a 2 x 16 frame buffer to an LCD1602 wrapper as address/character
// requests. Define MFE_LCD1602_AUTO_REFRESH_EN to add a periodic idle refresh.
module mfe_lcd1602_text_writer
    import mfe_lcd1602_pkg::*;
#(
    parameter int                           REFRESH_CNT_WIDTH = 24,
    parameter logic [REFRESH_CNT_WIDTH-1:0] REFRESH_CNT_MAX   = 24'd9999999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       update,
    output logic       busy,
    output logic       frame_done,
    input  logic       lcd_ready,
    output logic       lcd_clear,
    output logic       lcd_home,
    output logic       lcd_cenb,
    output logic       lcd_disp,
    output logic [1:0] lcd_shift,
    output logic       lcd_cmd,
    output logic       lcd_vld,
    output logic [7:0] lcd_dat
);

    state_t     state;
    logic [4:0] ptr;
    logic       last_was_addr;
    logic       wait_first;
    logic       refresh_req;
    logic       refresh_tick;
    logic       refresh_set;
    logic [7:0] buf_char;

    assign lcd_clear = 1'b0;
    assign lcd_home  = 1'b0;
    assign lcd_cenb  = 1'b0;
    assign lcd_disp  = 1'b0;
    assign lcd_shift = 2'b00;

    mfe_lcd1602_frame_buf u_frame_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (ptr),
        .rd_data (buf_char)
    );

`ifdef MFE_LCD1602_AUTO_REFRESH_EN
    logic [REFRESH_CNT_WIDTH-1:0] refresh_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (state != S_IDLE || refresh_cnt == REFRESH_CNT_MAX) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign refresh_tick = (state == S_IDLE) && (refresh_cnt == REFRESH_CNT_MAX);
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = ^REFRESH_CNT_MAX;
    assign refresh_tick = 1'b0;
`endif

    // A write landing mid-frame re-arms the request so the new text is sent
    // in one follow-up frame.
    assign refresh_set = update | (wr_en & busy) | refresh_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            last_was_addr <= 1'b0;
            wait_first    <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            lcd_cmd       <= 1'b0;
            lcd_vld       <= 1'b0;
            lcd_dat       <= 8'h00;
            refresh_req   <= 1'b1;
        end else begin
            // NOTE: strobes default low each cycle so every issue is exactly one
            // cycle wide; only the issuing branch raises them.
            lcd_cmd    <= 1'b0;
            lcd_vld    <= 1'b0;
            frame_done <= 1'b0;

            if (refresh_set) begin
                refresh_req <= 1'b1;
            end else if (state == S_IDLE && refresh_req) begin
                refresh_req <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (refresh_req) begin
                        ptr   <= '0;
                        busy  <= 1'b1;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (lcd_ready) begin
                        lcd_cmd       <= 1'b1;
                        lcd_dat       <= line_addr(ptr[4]);
                        last_was_addr <= 1'b1;
                        wait_first    <= 1'b1;
                        state         <= S_WAIT;
                    end
                end
                S_CHAR: begin
                    if (lcd_ready) begin
                        lcd_vld       <= 1'b1;
                        lcd_dat       <= buf_char;
                        last_was_addr <= 1'b0;
                        wait_first    <= 1'b1;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The wrapper drops ready one cycle after a request, so the
                    // first wait cycle still shows the stale ready level.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (lcd_ready) begin
                        if (last_was_addr) begin
                            state <= S_CHAR;
                        end else if (ptr == BUF_LAST) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else if (ptr == LINE0_LAST) begin
                            ptr   <= ptr + 5'd1;
                            state <= S_ADDR;
                        end else begin
                            ptr   <= ptr + 5'd1;
                            state <= S_CHAR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfe_lcd1602_text_writer.sv
// Self-checking bench for mfe_lcd1602_text_writer: a ready-model wrapper
// feeds the DUT and a scoreboard compares every request and frame_done pulse.
module tb_mfe_lcd1602_text_writer;

    typedef enum logic [1:0] {K_ADDR, K_CHAR, K_DONE} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [7:0] dat;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       update = 1'b0;
    logic       busy, frame_done, lcd_ready;
    logic       lcd_clear, lcd_home, lcd_cenb, lcd_disp;
    logic [1:0] lcd_shift;
    logic       lcd_cmd, lcd_vld;
    logic [7:0] lcd_dat;

    logic       model_ready = 1'b1;
    logic       ready_en = 1'b1;
    int         hold = 0;

    item_t      exp_q[$];
    logic [7:0] model_buf [32];
    int         checks = 0;
    int         failures = 0;
    int         req_count = 0;
    int         idle_run = 0;
    int         last_gap = 0;

    always #5 clk = ~clk;

    assign lcd_ready = model_ready & ready_en;

    mfe_lcd1602_text_writer #(
        .REFRESH_CNT_WIDTH (24),
        .REFRESH_CNT_MAX   (24'd99)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .update     (update),
        .busy       (busy),
        .frame_done (frame_done),
        .lcd_ready  (lcd_ready),
        .lcd_clear  (lcd_clear),
        .lcd_home   (lcd_home),
        .lcd_cenb   (lcd_cenb),
        .lcd_disp   (lcd_disp),
        .lcd_shift  (lcd_shift),
        .lcd_cmd    (lcd_cmd),
        .lcd_vld    (lcd_vld),
        .lcd_dat    (lcd_dat)
    );

    // Wrapper model: ready drops for 3 cycles after every request.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else if (lcd_cmd || lcd_vld) begin
            hold = 3;
        end else if (hold > 0) begin
            hold = hold - 1;
        end
        model_ready = (hold == 0);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        item_t obs;
        item_t expv;
        logic  got;
        got = 1'b0;
        obs = '0;
        if (rst_n) begin
            if (lcd_cmd && lcd_vld) begin
                checks++;
                failures++;
                $display("FAIL strobe_overlap cmd=%0b vld=%0b required one-hot", lcd_cmd, lcd_vld);
            end
            if (lcd_cmd) begin
                obs.kind = K_ADDR; obs.dat = lcd_dat; got = 1'b1;
            end else if (lcd_vld) begin
                obs.kind = K_CHAR; obs.dat = lcd_dat; got = 1'b1;
            end else if (frame_done) begin
                obs.kind = K_DONE; obs.dat = 8'h00; got = 1'b1;
            end
            if (got) begin
                if (obs.kind != K_DONE) req_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected kind=%0d dat=%02h required nothing", obs.kind, obs.dat);
                end else begin
                    expv = exp_q.pop_front();
                    if (obs !== expv) begin
                        failures++;
                        $display("FAIL sb_item kind=%0d dat=%02h required kind=%0d dat=%02h",
                                 obs.kind, obs.dat, expv.kind, expv.dat);
                    end
                end
            end
            if (!busy) begin
                idle_run++;
            end else if (idle_run > 0) begin
                last_gap = idle_run;
                idle_run = 0;
            end
        end else begin
            idle_run = 0;
        end
    end

    task automatic push_item(input kind_t k, input logic [7:0] d);
        item_t it;
        it.kind = k;
        it.dat  = d;
        exp_q.push_back(it);
    endtask

    task automatic push_frame();
        push_item(K_ADDR, 8'h00);
        for (int i = 0; i < 16; i++) push_item(K_CHAR, model_buf[i]);
        push_item(K_ADDR, 8'h40);
        for (int i = 16; i < 32; i++) push_item(K_CHAR, model_buf[i]);
        push_item(K_DONE, 8'h00);
    endtask

    task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_reqs(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (req_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (req_count < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout reqs=%0d required %0d", name, req_count, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, frame_done, lcd_cmd, lcd_vld} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required 0000", {busy, frame_done, lcd_cmd, lcd_vld});
        end
        checks++;
        if (lcd_dat !== 8'h00) begin
            failures++;
            $display("FAIL reset_dat got=%02h required 00", lcd_dat);
        end
        checks++;
        if ({lcd_clear, lcd_home, lcd_cenb, lcd_disp, lcd_shift} !== 6'b0) begin
            failures++;
            $display("FAIL tied_outputs got=%b required 000000",
                     {lcd_clear, lcd_home, lcd_cenb, lcd_disp, lcd_shift});
        end
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        push_frame();
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain(1000, "reset_frame");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_busy got=%b required 0", busy);
        end
    endtask

    task automatic test_hello();
        int base;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        base = req_count;
        for (int i = 0; i < 5; i++) begin
            write_buf(5'(i), hello[i]);
            model_buf[i] = hello[i];
        end
        write_buf(5'd16, 8'h57);
        model_buf[16] = 8'h57;
        checks++;
        if (req_count !== base || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_write_no_frame reqs=%0d busy=%b required %0d 0", req_count, busy, base);
        end
        push_frame();
        pulse_update();
        wait_drain(1000, "hello_frame");
    endtask

    task automatic test_write_during_frame();
        int base;
        model_buf[31] = 8'h41;
        push_frame();
        model_buf[0] = 8'h5A;
        push_frame();
        base = req_count;
        pulse_update();
        wait_reqs(base + 22, 500, "ptr20");
        write_buf(5'd31, 8'h41);
        write_buf(5'd0, 8'h5A);
        wait_drain(2000, "write_during_frame");
        base = req_count;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (req_count !== base || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_extra_frame reqs=%0d busy=%b required %0d 0", req_count, busy, base);
        end
    endtask

    task automatic test_ready_stall();
        int base;
        push_frame();
        ready_en = 1'b0;
        base = req_count;
        pulse_update();
        repeat (1000) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_busy got=%b required 1", busy);
        end
        checks++;
        if (req_count !== base) begin
            failures++;
            $display("FAIL stall_no_strobe reqs=%0d required %0d", req_count, base);
        end
        ready_en = 1'b1;
        wait_drain(1000, "stall_frame");
    endtask

    task automatic test_reset_mid_frame();
        int base;
        push_frame();
        base = req_count;
        pulse_update();
        wait_reqs(base + 12, 500, "ptr10");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, lcd_cmd, lcd_vld} !== 4'b0000 || lcd_dat !== 8'h00) begin
            failures++;
            $display("FAIL async_reset flags=%b dat=%02h required 0000 00",
                     {busy, frame_done, lcd_cmd, lcd_vld}, lcd_dat);
        end
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        push_frame();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(1000, "restart_frame");
    endtask

    task automatic test_auto_refresh();
`ifdef MFE_LCD1602_AUTO_REFRESH_EN
        push_frame();
        push_frame();
        wait_drain(2000, "auto_frames");
        // Idle span between frames: 100 counter cycles plus the request flop.
        checks++;
        if (last_gap < 100 || last_gap > 101) begin
            failures++;
            $display("FAIL auto_period gap=%0d required 100..101", last_gap);
        end
`else
        int base;
        base = req_count;
        repeat (300) @(negedge clk);
        #1;
        checks++;
        if (req_count !== base || busy !== 1'b0) begin
            failures++;
            $display("FAIL no_auto_refresh reqs=%0d busy=%b required %0d 0", req_count, busy, base);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_hello();
        test_write_during_frame();
        test_ready_stall();
        test_reset_mid_frame();
        test_auto_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
